// File: rtl/meter_display.sv
// Parking-meter readout: saturating binary-to-BCD conversion, 4-digit 7-segment
// multiplexing, and the low-time / expired blink rules.
module meter_display #(
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int LOW_THRESH  = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bcount,
    input  logic             half_tick,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [15:0]      bcd
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    conv_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [15:0]      scratch;
    logic [15:0]      adj;
    logic [IW-1:0]    iter;
    logic [WIDTH-1:0] bsat;
    logic [31:0]      bext;

    logic [CW-1:0]    refresh_cnt;
    logic [1:0]       digit_idx;
    logic [1:0]       phase;
    logic [31:0]      disp_val;
    logic             disp_on;
    logic [3:0]       nib;

    assign dp = 1'b1;

    // Four BCD digits cap the displayable value at 9999.
    always_comb begin
        bext = 32'(bcount);
        bsat = bcount;
        if (bext > 32'd9999)
            bsat = WIDTH'(32'd9999);
    end

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Free-running converter; bcd is only written in LOAD so it never shows a partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sreg    <= bsat;
                    scratch <= '0;
                    iter    <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {scratch, sreg} <= {adj, sreg} << 1;
                    iter <= iter + 1'b1;
                    if (iter == IW'(WIDTH - 1))
                        state <= LOAD;
                end
                LOAD: begin
                    bcd   <= scratch;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            phase       <= '0;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (half_tick)
                phase <= phase + 2'd1;
        end
    end

    // Blink mode follows the displayed value, not the raw input.
    always_comb begin
        disp_val = 32'(bcd[15:12]) * 32'd1000 + 32'(bcd[11:8]) * 32'd100
                 + 32'(bcd[7:4]) * 32'd10 + 32'(bcd[3:0]);
        if (disp_val == 32'd0)
            disp_on = ~phase[1];
        else if (disp_val < $unsigned(LOW_THRESH))
            disp_on = ~phase[0];
        else
            disp_on = 1'b1;
        nib = bcd[{digit_idx, 2'b00} +: 4];
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else if (disp_on) begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_decode(nib);
        end else begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end
    end

endmodule

// File: tb/tb_meter_display.sv
// Randomized self-checking bench for meter_display against a decimal-arithmetic reference model.
module tb_meter_display;

    localparam int WIDTH = 14;
    localparam int RDIV  = 4;
    localparam int LOWT  = 200;
    localparam int CONV  = WIDTH + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             half_tick = 1'b0;
    logic [WIDTH-1:0] bcount = '0;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;
    logic [15:0]      bcd;

    int errors = 0;
    int checks = 0;

    meter_display #(.WIDTH(WIDTH), .REFRESH_DIV(RDIV), .LOW_THRESH(LOWT)) dut (
        .clk(clk), .reset(reset), .bcount(bcount), .half_tick(half_tick),
        .an(an), .seg(seg), .dp(dp), .bcd(bcd)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    // Reference model: edges counted since reset; conversion window is CONV edges,
    // capture on the first, result visible after the last.
    int          k = 0, cap = 0, m_idx = 0, m_phase = 0, mv = 0, md = 0;
    bit          mon;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_an = 4'hF;
    logic [6:0]  m_seg = 7'h7F;

    always @(posedge clk) begin
        if (reset) begin
            k = 0; m_idx = 0; m_phase = 0; m_bcd = '0; m_an = 4'hF; m_seg = 7'h7F;
        end else begin
            mv = from_bcd(m_bcd);
            if (mv == 0)         mon = (m_phase < 2);
            else if (mv < LOWT)  mon = (m_phase % 2 == 0);
            else                 mon = 1'b1;
            md = (mv / (10 ** m_idx)) % 10;
            m_an  = mon ? ~(4'b0001 << m_idx) : 4'hF;
            m_seg = mon ? seg_tbl[md] : 7'h7F;
            if (k % CONV == 0)        cap = (int'(bcount) > 9999) ? 9999 : int'(bcount);
            if (k % CONV == CONV - 1) m_bcd = to_bcd(cap);
            if (k % RDIV == RDIV - 1) m_idx = (m_idx + 1) % 4;
            if (half_tick)            m_phase = (m_phase + 1) % 4;
            k++;
        end
    end

    task automatic test_reset();
        reset = 1'b1; bcount = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F) begin
                errors++;
                $display("FAIL reset_outputs an=%b seg=%b required an=1111 seg=1111111", an, seg);
            end
        end
        checks++;
        if (bcd !== 16'h0000 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_bcd_dp bcd=%h dp=%b required bcd=0000 dp=1", bcd, dp);
        end
        reset = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (bcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bcd_settled bcd=%h required 0000", bcd);
        end
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (an === 4'hF || seg !== 7'b1000000 || an !== m_an) begin
                errors++;
                $display("FAIL reset_zero_digits an=%b seg=%b required an=%b seg=1000000", an, seg, m_an);
            end
        end
    endtask

    task automatic test_convert();
        int n;
        logic [6:0] exp_seg;
        bcount = 14'd1234;
        n = 0;
        while (bcd !== 16'h1234 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (bcd !== 16'h1234 || m_bcd !== 16'h1234) begin
            errors++;
            $display("FAIL convert_1234 bcd=%h required 1234 (model %h)", bcd, m_bcd);
        end
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: exp_seg = 7'b0011001;
                4'b1101: exp_seg = 7'b0110000;
                4'b1011: exp_seg = 7'b0100100;
                4'b0111: exp_seg = 7'b1111001;
                default: exp_seg = 7'bxxxxxxx;
            endcase
            checks++;
            if (an !== m_an || seg !== m_seg || seg !== exp_seg) begin
                errors++;
                $display("FAIL convert_mux an=%b seg=%b required an=%b seg=%b", an, seg, m_an, m_seg);
            end
        end
    endtask

    task automatic test_saturation();
        int          vals [5] = '{12000, 9999, 10000, 16383, 9998};
        logic [15:0] exps [5] = '{16'h9999, 16'h9999, 16'h9999, 16'h9999, 16'h9998};
        for (int i = 0; i < 5; i++) begin
            bcount = WIDTH'(vals[i]);
            repeat (2 * CONV + 2) @(negedge clk);
            checks++;
            if (bcd !== exps[i] || m_bcd !== exps[i]) begin
                errors++;
                $display("FAIL saturation in=%0d bcd=%h required %h", vals[i], bcd, exps[i]);
            end
        end
    endtask

    task automatic pulse_half_tick();
        half_tick = 1'b1;
        @(negedge clk);
        half_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_blink(input int value, input logic [3:0] on_pat, input string name);
        int n;
        bcount = WIDTH'(value);
        repeat (2 * CONV + 2) @(negedge clk);
        n = 0;
        while (m_phase != 0 && n < 4) begin pulse_half_tick(); n++; end
        for (int p = 0; p < 4; p++) begin
            repeat (4) begin
                @(negedge clk);
                checks++;
                if ((an !== 4'hF) !== on_pat[p] || an !== m_an || seg !== m_seg) begin
                    errors++;
                    $display("FAIL blink_%s phase=%0d an=%b seg=%b required on=%b an=%b seg=%b",
                             name, p, an, seg, on_pat[p], m_an, m_seg);
                end
                if (value == 0 && on_pat[p]) begin
                    checks++;
                    if (seg !== 7'b1000000) begin
                        errors++;
                        $display("FAIL blink_%s_digit seg=%b required 1000000", name, seg);
                    end
                end
            end
            pulse_half_tick();
        end
    endtask

    task automatic test_midconv();
        int n;
        logic [15:0] prev;
        bit seen_a;
        prev = bcd;
        n = 0;
        while (k % CONV != 0 && n < 40) begin @(negedge clk); n++; end
        bcount = 14'd1234;
        repeat (5) @(negedge clk);
        bcount = 14'd5678;
        seen_a = 0;
        repeat (2 * CONV + 2) begin
            @(negedge clk);
            if (bcd === 16'h1234) seen_a = 1;
            checks++;
            if (bcd !== m_bcd || (bcd !== prev && bcd !== 16'h1234 && bcd !== 16'h5678)) begin
                errors++;
                $display("FAIL midconv_value bcd=%h required %h", bcd, m_bcd);
            end
        end
        checks++;
        if (!seen_a || bcd !== 16'h5678) begin
            errors++;
            $display("FAIL midconv_sequence seen1234=%0d bcd=%h required 1 and 5678", seen_a, bcd);
        end
        n = 0;
        while (k % CONV != 0 && n < 40) begin @(negedge clk); n++; end
        bcount = 14'd4321;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bcount = '0;
        checks++;
        if (bcd !== 16'h0000) begin
            errors++;
            $display("FAIL midconv_reset bcd=%h required 0000", bcd);
        end
        repeat (2 * CONV) begin
            @(negedge clk);
            checks++;
            if (bcd !== 16'h0000) begin
                errors++;
                $display("FAIL midconv_stale bcd=%h required 0000", bcd);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c % 23 == 0)
                bcount = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 250))
                                                     : WIDTH'($urandom_range(0, 16383));
            half_tick = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            checks++;
            if (an !== m_an || seg !== m_seg || bcd !== m_bcd) begin
                errors++;
                $display("FAIL random cyc=%0d an=%b seg=%b bcd=%h required an=%b seg=%b bcd=%h",
                         c, an, seg, bcd, m_an, m_seg, m_bcd);
            end
        end
        half_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_convert();
        test_saturation();
        test_blink(150, 4'b0101, "low150");
        test_blink(199, 4'b0101, "low199");
        test_blink(200, 4'b1111, "normal200");
        test_blink(0,   4'b0011, "zero");
        test_midconv();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
